// File: rtl/vga_sync_receiver.sv
// Receive side of the 640x480@60 VGA timing: recovers pixel coordinates, checks line/frame
// lengths, locks after consecutive good frames. Optional macro VGA_RX_MEASURE_EN adds length outputs.
module vga_sync_receiver #(
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int H_ACTIVE_START = 144,
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE_START = 35,
    parameter int V_ACTIVE       = 480,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic [9:0]  VGA_R,
    input  logic [9:0]  VGA_G,
    input  logic [9:0]  VGA_B,
    output logic        pixValid,
    output logic [9:0]  pixX,
    output logic [9:0]  pixY,
    output logic [9:0]  pixR,
    output logic [9:0]  pixG,
    output logic [9:0]  pixB,
    output logic        locked,
    output logic        frameStart,
    output logic        syncErr
`ifdef VGA_RX_MEASURE_EN
    ,
    output logic [10:0] measLineLen,
    output logic [10:0] measFrameLines
`endif
);

    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [11:0] H_TOTAL_C   = 12'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_C   = 12'(V_TOTAL);
    localparam logic [10:0] H_ACT_FIRST = 11'(H_ACTIVE_START);
    localparam logic [10:0] H_ACT_LAST  = 11'(H_ACTIVE_START + H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_FIRST = 11'(V_ACTIVE_START);
    localparam logic [10:0] V_ACT_LAST  = 11'(V_ACTIVE_START + V_ACTIVE - 1);
    localparam logic [2:0]  LOCK_C      = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic        hs_s1_r, vs_s1_r, hs_prev_r, vs_prev_r;
    logic [9:0]  r_s1_r, g_s1_r, b_s1_r;
    logic [9:0]  r_al_r, g_al_r, b_al_r;
    logic [10:0] hcnt_r, vcnt_r;
    logic        vs_pending_r;
    state_t      state_r, state_nxt_s;
    logic [2:0]  good_r, good_nxt_s;
    logic        err_s;
    logic        locked_r, sync_err_r, frame_start_r;
    logic        pix_valid_r;
    logic [9:0]  pix_x_r, pix_y_r, pix_r_r, pix_g_r, pix_b_r;

    logic        hs_fall_s, vs_fall_s, line0_s;
    logic [11:0] line_len_s, frame_len_s;
    logic        line_ok_s, frame_ok_s;
    logic        active_s, valid_s;

    assign hs_fall_s   = hs_prev_r & ~hs_s1_r;
    assign vs_fall_s   = vs_prev_r & ~vs_s1_r;
    // An HS fall opens line 0 when a VS fall is pending or lands in the same cycle.
    assign line0_s     = hs_fall_s & (vs_pending_r | vs_fall_s);
    assign line_len_s  = {1'b0, hcnt_r} + 12'd1;
    assign frame_len_s = {1'b0, vcnt_r} + 12'd1;
    assign line_ok_s   = (line_len_s == H_TOTAL_C);
    assign frame_ok_s  = (frame_len_s == V_TOTAL_C);

    assign active_s = (hcnt_r >= H_ACT_FIRST) && (hcnt_r <= H_ACT_LAST) &&
                      (vcnt_r >= V_ACT_FIRST) && (vcnt_r <= V_ACT_LAST);
    assign valid_s  = locked_r & active_s;

    // Input stage plus one alignment stage so RGB lines up with the recovered counters.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hs_s1_r   <= 1'b1;
            vs_s1_r   <= 1'b1;
            hs_prev_r <= 1'b1;
            vs_prev_r <= 1'b1;
            r_s1_r    <= 10'd0;
            g_s1_r    <= 10'd0;
            b_s1_r    <= 10'd0;
            r_al_r    <= 10'd0;
            g_al_r    <= 10'd0;
            b_al_r    <= 10'd0;
        end else begin
            hs_s1_r   <= VGA_HS;
            vs_s1_r   <= VGA_VS;
            hs_prev_r <= hs_s1_r;
            vs_prev_r <= vs_s1_r;
            r_s1_r    <= VGA_R;
            g_s1_r    <= VGA_G;
            b_s1_r    <= VGA_B;
            r_al_r    <= r_s1_r;
            g_al_r    <= g_s1_r;
            b_al_r    <= b_s1_r;
        end
    end

    // Horizontal/vertical position counters, both saturating.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hcnt_r       <= 11'd0;
            vcnt_r       <= 11'd0;
            vs_pending_r <= 1'b0;
        end else begin
            if (hs_fall_s) begin
                hcnt_r <= 11'd0;
            end else if (hcnt_r != CNT_MAX) begin
                hcnt_r <= hcnt_r + 11'd1;
            end else begin
                hcnt_r <= hcnt_r;
            end
            if (line0_s) begin
                vcnt_r <= 11'd0;
            end else if (hs_fall_s && (vcnt_r != CNT_MAX)) begin
                vcnt_r <= vcnt_r + 11'd1;
            end else begin
                vcnt_r <= vcnt_r;
            end
            if (line0_s) begin
                vs_pending_r <= 1'b0;
            end else if (vs_fall_s) begin
                vs_pending_r <= 1'b1;
            end else begin
                vs_pending_r <= vs_pending_r;
            end
        end
    end

    // Lock FSM next state; errors are only reported when falling out of lock.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        err_s       = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (line0_s) begin
                    state_nxt_s = ST_MEASURE;
                    good_nxt_s  = 3'd0;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (hs_fall_s && !line_ok_s) begin
                    state_nxt_s = ST_SEARCH;
                    good_nxt_s  = 3'd0;
                end else if (line0_s) begin
                    if (!frame_ok_s) begin
                        state_nxt_s = ST_SEARCH;
                        good_nxt_s  = 3'd0;
                    end else if ((good_r + 3'd1) == LOCK_C) begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = good_r + 3'd1;
                    end else begin
                        good_nxt_s  = good_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if ((hs_fall_s && !line_ok_s) || (line0_s && !frame_ok_s) ||
                    (hcnt_r == CNT_MAX)) begin
                    state_nxt_s = ST_SEARCH;
                    good_nxt_s  = 3'd0;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
                good_nxt_s  = 3'd0;
            end
        endcase
    end

    // FSM state and status pulses.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_SEARCH;
            good_r        <= 3'd0;
            locked_r      <= 1'b0;
            sync_err_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            good_r        <= good_nxt_s;
            locked_r      <= (state_nxt_s == ST_LOCKED);
            sync_err_r    <= err_s;
            frame_start_r <= line0_s;
        end
    end

    // Output stage; tags and data hold while no valid pixel is present.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pix_valid_r <= 1'b0;
            pix_x_r     <= 10'd0;
            pix_y_r     <= 10'd0;
            pix_r_r     <= 10'd0;
            pix_g_r     <= 10'd0;
            pix_b_r     <= 10'd0;
        end else begin
            pix_valid_r <= valid_s;
            if (valid_s) begin
                pix_x_r <= 10'(hcnt_r - H_ACT_FIRST);
                pix_y_r <= 10'(vcnt_r - V_ACT_FIRST);
                pix_r_r <= r_al_r;
                pix_g_r <= g_al_r;
                pix_b_r <= b_al_r;
            end else begin
                pix_x_r <= pix_x_r;
                pix_y_r <= pix_y_r;
                pix_r_r <= pix_r_r;
                pix_g_r <= pix_g_r;
                pix_b_r <= pix_b_r;
            end
        end
    end

    assign pixValid   = pix_valid_r;
    assign pixX       = pix_x_r;
    assign pixY       = pix_y_r;
    assign pixR       = pix_r_r;
    assign pixG       = pix_g_r;
    assign pixB       = pix_b_r;
    assign locked     = locked_r;
    assign frameStart = frame_start_r;
    assign syncErr    = sync_err_r;

`ifdef VGA_RX_MEASURE_EN
    logic [10:0] meas_line_r, meas_frame_r;

    // Raw length capture, independent of lock state; 2048 saturates to 2047.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            meas_line_r  <= 11'd0;
            meas_frame_r <= 11'd0;
        end else begin
            if (hs_fall_s) begin
                meas_line_r <= (hcnt_r == CNT_MAX) ? CNT_MAX : line_len_s[10:0];
            end else begin
                meas_line_r <= meas_line_r;
            end
            if (line0_s) begin
                meas_frame_r <= (vcnt_r == CNT_MAX) ? CNT_MAX : frame_len_s[10:0];
            end else begin
                meas_frame_r <= meas_frame_r;
            end
        end
    end

    assign measLineLen    = meas_line_r;
    assign measFrameLines = meas_frame_r;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 40x20 timing so whole frames stay short.
module tb_vga_sync_receiver;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HAS = 8;
    localparam int HA  = 24;
    localparam int VAS = 3;
    localparam int VA  = 14;
    localparam int HSW = 4;
    localparam int VSW = 2;

    logic       clk = 1'b0;
    logic       Reset;
    logic       VGA_HS, VGA_VS;
    logic [9:0] VGA_R, VGA_G, VGA_B;
    logic       pixValid, locked, frameStart, syncErr;
    logic [9:0] pixX, pixY, pixR, pixG, pixB;
`ifdef VGA_RX_MEASURE_EN
    logic [10:0] measLineLen, measFrameLines;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE_START(HAS), .H_ACTIVE(HA),
        .V_ACTIVE_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .Reset(Reset), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pixValid(pixValid), .pixX(pixX), .pixY(pixY),
        .pixR(pixR), .pixG(pixG), .pixB(pixB),
        .locked(locked), .frameStart(frameStart), .syncErr(syncErr)
`ifdef VGA_RX_MEASURE_EN
        , .measLineLen(measLineLen), .measFrameLines(measFrameLines)
`endif
    );

    bit mark_en  = 1'b0;
    bit vs_early = 1'b0;
    int line_cyc [VT];

    // Monitor statistics (written only here).
    int v_cnt = 0, nz_cnt = 0, seq_err = 0, fs_cnt = 0, err_cnt = 0, err_wide = 0;
    int lock_cnt = 0, lock_cyc = 0, err_cyc = 0, mark_cyc = 0, ex = 0, ey = 0;
    logic [9:0] fx = 10'd0, fy = 10'd0, lx = 10'd0, ly = 10'd0;
    logic [9:0] mx = 10'd0, my = 10'd0, mr = 10'd0, mg = 10'd0, mb = 10'd0;
    bit got_first = 1'b0, prev_err = 1'b0, prev_lock = 1'b0;

    always @(negedge clk) begin
        prev_err  <= (syncErr === 1'b1);
        prev_lock <= (locked === 1'b1);
        if (syncErr === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            if (prev_err) err_wide <= err_wide + 1;
        end
        if (locked === 1'b1 && !prev_lock) begin
            lock_cnt <= lock_cnt + 1;
            lock_cyc <= cyc;
        end
        if (frameStart === 1'b1) begin
            fs_cnt    <= fs_cnt + 1;
            ex        <= 0;
            ey        <= 0;
            got_first <= 1'b0;
        end else if (pixValid === 1'b1) begin
            v_cnt <= v_cnt + 1;
            if (pixX !== 10'(ex) || pixY !== 10'(ey)) seq_err <= seq_err + 1;
            if (ex == HA - 1) begin
                ex <= 0;
                ey <= ey + 1;
            end else begin
                ex <= ex + 1;
            end
            if (!got_first) begin
                fx <= pixX;
                fy <= pixY;
                got_first <= 1'b1;
            end
            lx <= pixX;
            ly <= pixY;
            if (pixR != 10'd0 || pixG != 10'd0 || pixB != 10'd0) begin
                nz_cnt   <= nz_cnt + 1;
                mark_cyc <= cyc;
                mx <= pixX; my <= pixY; mr <= pixR; mg <= pixG; mb <= pixB;
            end
        end
    end

    task automatic drive_line(input int len, input int ln);
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            if (p == 0) line_cyc[ln] = cyc;
            VGA_HS = (p < HSW) ? 1'b0 : 1'b1;
            VGA_VS = ((ln < VSW) || (vs_early && ln == VT - 1 && p >= 20)) ? 1'b0 : 1'b1;
            if (mark_en && ln == VAS && p == HAS) begin
                VGA_R = 10'h3FF; VGA_G = 10'h155; VGA_B = 10'h0AA;
            end else begin
                VGA_R = 10'h000; VGA_G = 10'h000; VGA_B = 10'h000;
            end
        end
    endtask

    task automatic drive_frame(input int hlen, input int bad_line, input int bad_len);
        for (int ln = 0; ln < VT; ln++) drive_line((ln == bad_line) ? bad_len : hlen, ln);
    endtask

    task automatic test_reset();
        Reset = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1;
        VGA_R = 10'd0; VGA_G = 10'd0; VGA_B = 10'd0;
        repeat (3) @(negedge clk);
        checks++; if (pixValid !== 1'b0) begin errors++; $display("FAIL reset_pixValid: got %b expected 0", pixValid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL reset_frameStart: got %b expected 0", frameStart); end
        checks++; if (syncErr !== 1'b0) begin errors++; $display("FAIL reset_syncErr: got %b expected 0", syncErr); end
        checks++; if (pixX !== 10'd0 || pixY !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", pixX, pixY); end
        checks++; if (pixR !== 10'd0 || pixG !== 10'd0 || pixB !== 10'd0) begin errors++; $display("FAIL reset_rgb: got %h/%h/%h expected 0/0/0", pixR, pixG, pixB); end
        Reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal_lock();
        int v0, f0;
        v0 = v_cnt; f0 = fs_cnt;
        drive_frame(HT, -1, 0);
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b0 || lock_cnt != 0) begin errors++; $display("FAIL early_lock: got locked=%b rises=%0d expected 0,0", locked, lock_cnt); end
        drive_frame(HT, -1, 0);
        checks++; if (lock_cyc != line_cyc[0] + 2) begin errors++; $display("FAIL lock_time: got cycle %0d expected %0d", lock_cyc, line_cyc[0] + 2); end
        checks++; if (v_cnt - v0 != HA * VA) begin errors++; $display("FAIL frame3_pixels: got %0d expected %0d", v_cnt - v0, HA * VA); end
        checks++; if (fx !== 10'd0 || fy !== 10'd0) begin errors++; $display("FAIL first_pixel: got %0d,%0d expected 0,0", fx, fy); end
        checks++; if (lx !== 10'(HA - 1) || ly !== 10'(VA - 1)) begin errors++; $display("FAIL last_pixel: got %0d,%0d expected %0d,%0d", lx, ly, HA - 1, VA - 1); end
        drive_frame(HT, -1, 0);
        checks++; if (v_cnt - v0 != 2 * HA * VA) begin errors++; $display("FAIL two_frames_pixels: got %0d expected %0d", v_cnt - v0, 2 * HA * VA); end
        checks++; if (fs_cnt - f0 != 4) begin errors++; $display("FAIL frame_starts: got %0d expected 4", fs_cnt - f0); end
        checks++; if (seq_err != 0 || err_cnt != 0) begin errors++; $display("FAIL nominal_clean: got seq_err=%0d syncErr=%0d expected 0,0", seq_err, err_cnt); end
    endtask

    task automatic test_long_line();
        int v0, e0, v1;
        v0 = v_cnt; e0 = err_cnt;
        drive_frame(HT, 5, HT + 1);
        checks++; if (err_cnt - e0 != 1 || err_wide != 0) begin errors++; $display("FAIL long_line_err: got pulses=%0d wide=%0d expected 1,0", err_cnt - e0, err_wide); end
        checks++; if (err_cyc != line_cyc[6] + 2) begin errors++; $display("FAIL long_line_err_time: got %0d expected %0d", err_cyc, line_cyc[6] + 2); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL long_line_unlock: got %b expected 0", locked); end
        checks++; if (v_cnt - v0 != 3 * HA) begin errors++; $display("FAIL long_line_pixels: got %0d expected %0d", v_cnt - v0, 3 * HA); end
        v1 = v_cnt;
        drive_frame(HT, -1, 0);
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b0 || v_cnt != v1) begin errors++; $display("FAIL relock_early: got locked=%b pixels=%0d expected 0,0", locked, v_cnt - v1); end
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b1 || v_cnt - v1 != HA * VA) begin errors++; $display("FAIL relock: got locked=%b pixels=%0d expected 1,%0d", locked, v_cnt - v1, HA * VA); end
    endtask

    task automatic test_pixel_data();
        int n0;
        n0 = nz_cnt;
        mark_en = 1'b1;
        drive_frame(HT, -1, 0);
        mark_en = 1'b0;
        checks++; if (nz_cnt - n0 != 1) begin errors++; $display("FAIL mark_count: got %0d expected 1", nz_cnt - n0); end
        checks++; if (mx !== 10'd0 || my !== 10'd0) begin errors++; $display("FAIL mark_xy: got %0d,%0d expected 0,0", mx, my); end
        checks++; if (mr !== 10'h3FF || mg !== 10'h155 || mb !== 10'h0AA) begin errors++; $display("FAIL mark_rgb: got %h/%h/%h expected 3ff/155/0aa", mr, mg, mb); end
        checks++; if (mark_cyc != line_cyc[VAS] + HAS + 3) begin errors++; $display("FAIL mark_latency: got %0d expected %0d", mark_cyc, line_cyc[VAS] + HAS + 3); end
    endtask

    task automatic test_vs_midline();
        int e0, f0, v0;
        e0 = err_cnt; f0 = fs_cnt; v0 = v_cnt;
        vs_early = 1'b1;
        drive_frame(HT, -1, 0);
        vs_early = 1'b0;
        drive_frame(HT, -1, 0);
        checks++; if (err_cnt != e0 || locked !== 1'b1) begin errors++; $display("FAIL vs_mid_lock: got err=%0d locked=%b expected 0,1", err_cnt - e0, locked); end
        checks++; if (fs_cnt - f0 != 2 || v_cnt - v0 != 2 * HA * VA) begin errors++; $display("FAIL vs_mid_frames: got fs=%0d pixels=%0d expected 2,%0d", fs_cnt - f0, v_cnt - v0, 2 * HA * VA); end
        checks++; if (seq_err != 0) begin errors++; $display("FAIL vs_mid_seq: got %0d expected 0", seq_err); end
    endtask

    task automatic test_hs_stuck();
        int e0;
        e0 = err_cnt;
        repeat (1900) @(negedge clk);
        checks++; if (err_cnt != e0 || locked !== 1'b1) begin errors++; $display("FAIL stuck_early: got err=%0d locked=%b expected 0,1", err_cnt - e0, locked); end
        repeat (200) @(negedge clk);
        checks++; if (err_cnt - e0 != 1 || locked !== 1'b0) begin errors++; $display("FAIL stuck_err: got err=%0d locked=%b expected 1,0", err_cnt - e0, locked); end
        checks++; if (err_wide != 0) begin errors++; $display("FAIL stuck_err_width: got %0d expected 0", err_wide); end
        drive_frame(HT, -1, 0);
        drive_frame(HT, -1, 0);
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stuck_relock: got %b expected 1", locked); end
    endtask

    task automatic test_reset_mid_frame();
        for (int ln = 0; ln < 7; ln++) drive_line(HT, ln);
        drive_line(20, 7);
        checks++; if (pixValid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", pixValid); end
        Reset = 1'b0;
        @(negedge clk);
        checks++; if (locked !== 1'b0 || pixValid !== 1'b0 || syncErr !== 1'b0 || frameStart !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got locked=%b valid=%b err=%b fs=%b expected 0,0,0,0", locked, pixValid, syncErr, frameStart);
        end
        @(negedge clk);
        Reset = 1'b1;
        drive_frame(HT, -1, 0);
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_relock_early: got %b expected 0", locked); end
        drive_frame(HT, -1, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_relock: got %b expected 1", locked); end
    endtask

    task automatic test_bad_line_len();
        int l0, e0, v0;
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        l0 = lock_cnt; e0 = err_cnt; v0 = v_cnt;
        for (int f = 0; f < 4; f++) drive_frame(HT + 2, -1, 0);
        checks++; if (lock_cnt != l0 || locked !== 1'b0) begin errors++; $display("FAIL bad_len_lock: got rises=%0d locked=%b expected 0,0", lock_cnt - l0, locked); end
        checks++; if (err_cnt != e0 || v_cnt != v0) begin errors++; $display("FAIL bad_len_quiet: got err=%0d pixels=%0d expected 0,0", err_cnt - e0, v_cnt - v0); end
`ifdef VGA_RX_MEASURE_EN
        checks++; if (measLineLen !== 11'(HT + 2)) begin errors++; $display("FAIL meas_line: got %0d expected %0d", measLineLen, HT + 2); end
        checks++; if (measFrameLines !== 11'(VT)) begin errors++; $display("FAIL meas_frame: got %0d expected %0d", measFrameLines, VT); end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_long_line();
        test_pixel_data();
        test_vs_midline();
        test_hs_stuck();
        test_reset_mid_frame();
        test_bad_line_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
